// File: rtl/spmv_pkg.sv
// Shared types and defaults for the SpMV row-tracking pipeline stages.
package spmv_pkg;

  localparam int NUM_ROWS_DEF = 16;
  localparam int PTR_W_DEF    = 8;
  localparam int ROW_W_DEF    = $clog2(NUM_ROWS_DEF);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SCAN   = 2'd1;
  localparam state_t ST_STREAM = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  // Token at the default matrix geometry; parametrised stages pack their own.
  typedef struct packed {
    logic [ROW_W_DEF-1:0] row;
    logic [PTR_W_DEF-1:0] nz_idx;
    logic                 last;
    logic                 empty;
  } tok_t;

endpackage

// File: rtl/spmv_out_reg.sv
// One-entry output register: loads only when free (empty or being drained),
// holds its token stable while the consumer stalls.
module spmv_out_reg #(
  parameter int W = $bits(spmv_pkg::tok_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] data_in,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         free
);

  assign free = !valid || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load && free) begin
      valid <= 1'b1;
      data  <= data_in;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/spmv_row_tracker.sv
// CSR row tracker: walks latched row pointers one row per cycle and tags each
// accepted nonzero with row / nonzero index / last-in-row, optionally emitting empty-row tokens.
module spmv_row_tracker
  import spmv_pkg::*;
#(
  parameter int NUM_ROWS   = NUM_ROWS_DEF,
  parameter int PTR_W      = PTR_W_DEF,
  parameter int ROW_W      = $clog2(NUM_ROWS),
  parameter int EMIT_EMPTY = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [(NUM_ROWS+1)*PTR_W-1:0] i_row_ptr,
  input  logic                        i_nz_valid,
  output logic                        o_nz_ready,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [ROW_W-1:0]            o_row,
  output logic [PTR_W-1:0]            o_nz_idx,
  output logic                        o_row_last,
  output logic                        o_row_empty,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_err
);

  localparam int VEC_W = (NUM_ROWS+1)*PTR_W;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [PTR_W-1:0] nz_idx;
    logic             last;
    logic             empty;
  } row_tok_t;

  state_t             state;
  logic [ROW_W:0]     row;
  logic [PTR_W-1:0]   k;
  logic [VEC_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_lo;
  logic [PTR_W-1:0]   ptr_hi;
  logic               row_end;
  logic               row_empty;
  logic               nz_last;
  logic               hs;
  logic               out_free;
  logic               load;
  logic               mono_err;
  row_tok_t           tok_in;
  row_tok_t           tok_out;

  assign ptr_lo    = ptr_q[int'(row)*PTR_W +: PTR_W];
  assign ptr_hi    = ptr_q[(int'(row)+1)*PTR_W +: PTR_W];
  assign row_end   = (row == (ROW_W+1)'(NUM_ROWS));
  assign row_empty = (ptr_hi == ptr_lo);
  // One extra bit so a row ending at the top pointer value still matches.
  assign nz_last   = (({1'b0, k} + (PTR_W+1)'(1)) == {1'b0, ptr_hi});

  assign o_nz_ready = (state == ST_STREAM) && out_free;
  assign hs         = i_nz_valid && o_nz_ready;
  assign o_busy     = (state == ST_SCAN) || (state == ST_STREAM);
  assign o_done     = (state == ST_DONE);

  always_comb begin
    mono_err = 1'b0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (i_row_ptr[(r+1)*PTR_W +: PTR_W] < i_row_ptr[r*PTR_W +: PTR_W]) begin
        mono_err = 1'b1;
      end
    end
  end

  always_comb begin
    load   = 1'b0;
    tok_in = '0;
    if (state == ST_SCAN && !row_end && row_empty && EMIT_EMPTY != 0) begin
      load         = 1'b1;
      tok_in.row   = row[ROW_W-1:0];
      tok_in.last  = 1'b1;
      tok_in.empty = 1'b1;
    end else if (hs) begin
      load          = 1'b1;
      tok_in.row    = row[ROW_W-1:0];
      tok_in.nz_idx = k;
      tok_in.last   = nz_last;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      row   <= '0;
      k     <= '0;
      ptr_q <= '0;
      o_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            ptr_q <= i_row_ptr;
            row   <= '0;
            k     <= i_row_ptr[PTR_W-1:0];
            o_err <= mono_err;
            state <= mono_err ? ST_DONE : ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (row_end) begin
            state <= ST_DONE;
          end else if (row_empty) begin
            // With empty tokens enabled the row only advances once its token is placed.
            if (EMIT_EMPTY == 0 || out_free) begin
              row <= row + (ROW_W+1)'(1);
            end
          end else begin
            state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (hs) begin
            k <= k + PTR_W'(1);
            if (nz_last) begin
              row   <= row + (ROW_W+1)'(1);
              state <= ST_SCAN;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  spmv_out_reg #(.W($bits(row_tok_t))) u_out_reg (
    .clk     (i_clk),
    .rst     (i_rst),
    .load    (load),
    .data_in (tok_in),
    .ready   (i_ready),
    .valid   (o_valid),
    .data    (tok_out),
    .free    (out_free)
  );

  assign o_row       = tok_out.row;
  assign o_nz_idx    = tok_out.nz_idx;
  assign o_row_last  = tok_out.last;
  assign o_row_empty = tok_out.empty;

endmodule

// File: tb/tb_spmv_row_tracker.sv
// Runs three tracker instances (16 rows with/without empty tokens, 4 rows) against a CSR token-list model.
module tb_spmv_row_tracker;

  typedef struct {
    int row;
    int idx;
    bit last;
    bit empty;
  } tok_m_t;

  logic         clk, rst;
  logic         start_e, start_s, start_4;
  logic [135:0] row_ptr16;
  logic [39:0]  row_ptr4;
  logic         nz_valid, rdy;

  logic       nzr_e, vld_e, last_e, emp_e, busy_e, done_e, err_e;
  logic [3:0] row_e;
  logic [7:0] idx_e;
  logic       nzr_s, vld_s, last_s, emp_s, busy_s, done_s, err_s;
  logic [3:0] row_s;
  logic [7:0] idx_s;
  logic       nzr_4, vld_4, last_4, emp_4, busy_4, done_4, err_4;
  logic [1:0] row_4;
  logic [7:0] idx_4;

  int n_cmp = 0;
  int n_bad = 0;
  tok_m_t q_e[$], q_s[$], q_4[$];
  int p16[$], p4[$];
  logic        hv[3];
  logic [31:0] ht[3];
  logic        prev_hs_e;

  spmv_row_tracker #(.NUM_ROWS(16), .PTR_W(8), .EMIT_EMPTY(1)) dut_e (
    .i_clk(clk), .i_rst(rst), .i_start(start_e), .i_row_ptr(row_ptr16),
    .i_nz_valid(nz_valid), .o_nz_ready(nzr_e), .o_valid(vld_e), .i_ready(rdy),
    .o_row(row_e), .o_nz_idx(idx_e), .o_row_last(last_e), .o_row_empty(emp_e),
    .o_busy(busy_e), .o_done(done_e), .o_err(err_e));

  spmv_row_tracker #(.NUM_ROWS(16), .PTR_W(8), .EMIT_EMPTY(0)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_start(start_s), .i_row_ptr(row_ptr16),
    .i_nz_valid(nz_valid), .o_nz_ready(nzr_s), .o_valid(vld_s), .i_ready(rdy),
    .o_row(row_s), .o_nz_idx(idx_s), .o_row_last(last_s), .o_row_empty(emp_s),
    .o_busy(busy_s), .o_done(done_s), .o_err(err_s));

  spmv_row_tracker #(.NUM_ROWS(4), .PTR_W(8), .EMIT_EMPTY(1)) dut_4 (
    .i_clk(clk), .i_rst(rst), .i_start(start_4), .i_row_ptr(row_ptr4),
    .i_nz_valid(nz_valid), .o_nz_ready(nzr_4), .o_valid(vld_4), .i_ready(rdy),
    .o_row(row_4), .o_nz_idx(idx_4), .o_row_last(last_4), .o_row_empty(emp_4),
    .o_busy(busy_4), .o_done(done_4), .o_err(err_4));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: every row in order; a nonempty row lists its nonzeros, an empty row one marker or nothing.
  function automatic void build(ref tok_m_t q[$], input int p[$], input bit emit);
    q.delete();
    for (int r = 0; r < p.size() - 1; r++) begin
      if (p[r+1] == p[r]) begin
        if (emit) q.push_back('{r, 0, 1'b1, 1'b1});
      end else begin
        for (int k = p[r]; k < p[r+1]; k++) q.push_back('{r, k, (k == p[r+1] - 1), 1'b0});
      end
    end
  endfunction

  task automatic set_ptrs();
    for (int r = 0; r <= 16; r++) row_ptr16[r*8 +: 8] = 8'(p16[r]);
    for (int r = 0; r <= 4; r++)  row_ptr4[r*8 +: 8]  = 8'(p4[r]);
    build(q_e, p16, 1'b1);
    build(q_s, p16, 1'b0);
    build(q_4, p4, 1'b1);
  endtask

  task automatic gen_q(ref int p[$], input int n, input bit top);
    int sum, base;
    int inc[$];
    sum = 0;
    for (int r = 0; r < n; r++) begin
      inc.push_back(int'($urandom_range(0, 3)));
      sum += inc[r];
    end
    base = top ? 255 - sum : int'($urandom_range(0, 255 - sum));
    p.delete();
    p.push_back(base);
    for (int r = 0; r < n; r++) p.push_back(p[r] + inc[r]);
  endtask

  task automatic mon(input int d, input string nm, input logic vld, input logic [3:0] row,
                     input logic [7:0] idx, input logic last, input logic emp, input logic nzr,
                     ref tok_m_t q[$]);
    tok_m_t t;
    logic [31:0] cur;
    cur = {18'b0, row, idx, last, emp};
    if (hv[d]) begin
      chk({nm, " stall_valid"}, 64'(vld), 64'd1);
      chk({nm, " stall_hold"}, 64'(cur), 64'(ht[d]));
    end
    if (vld && !rdy) chk({nm, " nz_ready_in_stall"}, 64'(nzr), 64'd0);
    if (vld && rdy) begin
      chk({nm, " tok_expected"}, 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        t = q.pop_front();
        chk({nm, " row"}, 64'(row), 64'(t.row));
        chk({nm, " nz_idx"}, 64'(idx), 64'(t.idx));
        chk({nm, " last"}, 64'(last), 64'(t.last));
        chk({nm, " empty"}, 64'(emp), 64'(t.empty));
      end
    end
    hv[d] = vld && !rdy;
    ht[d] = cur;
  endtask

  task automatic step(input bit rnd);
    @(negedge clk);
    if (prev_hs_e) chk("e latency", 64'({vld_e, emp_e}), 64'b10);
    prev_hs_e = nz_valid && nzr_e;
    mon(0, "e", vld_e, row_e, idx_e, last_e, emp_e, nzr_e, q_e);
    mon(1, "s", vld_s, row_s, idx_s, last_s, emp_s, nzr_s, q_s);
    mon(2, "4", vld_4, {2'b00, row_4}, idx_4, last_4, emp_4, nzr_4, q_4);
    @(posedge clk);
    #1;
    if (rnd) begin
      nz_valid = ($urandom_range(0, 3) != 0);
      rdy      = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic kick(input bit rnd);
    start_e = 1'b1; start_s = 1'b1; start_4 = 1'b1;
    step(rnd);
    start_e = 1'b0; start_s = 1'b0; start_4 = 1'b0;
    chk("start busy", 64'({busy_e, busy_s, busy_4, err_e, err_s, err_4}), 64'b111000);
  endtask

  task automatic drain(input bit rnd);
    int cyc;
    cyc = 0;
    while (!(done_e && done_s && done_4 && !vld_e && !vld_s && !vld_4 &&
             q_e.size() == 0 && q_s.size() == 0 && q_4.size() == 0) && cyc < 3000) begin
      step(rnd);
      cyc++;
    end
    chk("run within budget", 64'(cyc < 3000), 64'd1);
    chk("tokens left e/s/4", 64'(q_e.size() + q_s.size() + q_4.size()), 64'd0);
    chk("end flags", 64'({done_e, done_s, done_4, busy_e, busy_s, busy_4, err_e, err_s, err_4}),
        64'b111000000);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " e"}, 64'({vld_e, nzr_e, busy_e, done_e, err_e, row_e, idx_e, last_e, emp_e}), 64'd0);
    chk({tag, " s"}, 64'({vld_s, nzr_s, busy_s, done_s, err_s, row_s, idx_s, last_s, emp_s}), 64'd0);
    chk({tag, " 4"}, 64'({vld_4, nzr_4, busy_4, done_4, err_4, row_4, idx_4, last_4, emp_4}), 64'd0);
  endtask

  task automatic clear_track();
    for (int d = 0; d < 3; d++) begin
      hv[d] = 1'b0;
      ht[d] = '0;
    end
    prev_hs_e = 1'b0;
  endtask

  initial begin
    logic [135:0] v;
    logic [135:0] saved;
    int c;
    clk = 1'b0; rst = 1'b1;
    start_e = 1'b0; start_s = 1'b0; start_4 = 1'b0;
    nz_valid = 1'b0; rdy = 1'b0;
    row_ptr16 = '0; row_ptr4 = '0;
    clear_track();

    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reference matrix, full throughput; 4-row instance uses an offset base.
    v = 136'h0a_09_09_09_07_07_07_07_04_04_04_03_02_02_01_00_00;
    p16.delete();
    for (int r = 0; r <= 16; r++) p16.push_back(int'(v[r*8 +: 8]));
    p4 = '{5, 6, 6, 8, 9};
    set_ptrs();
    chk("model e count", 64'(q_e.size()), 64'd19);
    chk("model s count", 64'(q_s.size()), 64'd10);
    nz_valid = 1'b1;
    rdy = 1'b1;
    kick(1'b0);
    drain(1'b0);

    // Backpressure in the middle of row 8.
    set_ptrs();
    kick(1'b0);
    c = 0;
    while (!(vld_e && row_e == 4'd8 && !emp_e) && c < 200) begin
      step(1'b0);
      c++;
    end
    chk("reached row 8", 64'(c < 200), 64'd1);
    rdy = 1'b0;
    repeat (3) begin
      step(1'b0);
      chk("bp nz_ready e", 64'(nzr_e), 64'd0);
    end
    rdy = 1'b1;
    drain(1'b0);

    // Non-monotonic pointers: ptr[3]=1 < ptr[2]=2.
    p16 = '{0, 0, 2, 1, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
    p4  = '{0, 1, 2, 1, 3};
    for (int r = 0; r <= 16; r++) row_ptr16[r*8 +: 8] = 8'(p16[r]);
    for (int r = 0; r <= 4; r++)  row_ptr4[r*8 +: 8]  = 8'(p4[r]);
    q_e.delete(); q_s.delete(); q_4.delete();
    start_e = 1'b1; start_s = 1'b1; start_4 = 1'b1;
    step(1'b0);
    start_e = 1'b0; start_s = 1'b0; start_4 = 1'b0;
    chk("err e", 64'({err_e, done_e, vld_e, nzr_e, busy_e}), 64'b11000);
    chk("err s", 64'({err_s, done_s, vld_s, nzr_s, busy_s}), 64'b11000);
    chk("err 4", 64'({err_4, done_4, vld_4, nzr_4, busy_4}), 64'b11000);
    repeat (3) step(1'b0);
    chk("err sticky", 64'({err_e, err_s, err_4}), 64'b111);

    // Start pulse during STREAM must be ignored.
    p16.delete();
    for (int r = 0; r <= 16; r++) p16.push_back(int'(v[r*8 +: 8]));
    p4 = '{5, 6, 6, 8, 9};
    set_ptrs();
    kick(1'b0);
    c = 0;
    while (!nzr_e && c < 100) begin
      step(1'b0);
      c++;
    end
    chk("reached stream", 64'(c < 100), 64'd1);
    saved = row_ptr16;
    row_ptr16 = ~saved;
    start_e = 1'b1;
    step(1'b0);
    start_e = 1'b0;
    row_ptr16 = saved;
    chk("start ignored", 64'({busy_e, err_e}), 64'b10);
    drain(1'b0);

    // Async reset mid-row, then a fresh replay from row 0.
    set_ptrs();
    kick(1'b0);
    repeat (9) step(1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("mid reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_track();
    set_ptrs();
    kick(1'b0);
    drain(1'b0);

    // All-empty matrices.
    p16.delete();
    for (int r = 0; r <= 16; r++) p16.push_back(7);
    p4 = '{200, 200, 200, 200, 200};
    set_ptrs();
    kick(1'b1);
    drain(1'b1);

    // Random monotonic matrices with random handshakes; some end exactly at 255.
    for (int it = 0; it < 8; it++) begin
      gen_q(p16, 16, (it % 3) == 0);
      gen_q(p4, 4, (it % 2) == 0);
      set_ptrs();
      kick(1'b1);
      drain(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
